// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall vectors, stage indices and sequencer state encoding
package pipe_ctrl_pkg;
  localparam int STAGES = 6;
  localparam int ST_PC  = 0;
  localparam int ST_IF  = 1;
  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;
  localparam int ST_WB  = 5;
  localparam logic [STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [STAGES-1:0] STALL_ID   = 6'b000111;
  localparam logic [STAGES-1:0] STALL_EX   = 6'b001111;
  localparam logic [STAGES-1:0] STALL_MEM  = 6'b011111;
  typedef enum logic [1:0] {S_RUN, S_DIV_BUSY, S_FLUSH} state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush request and control bundle between pipeline and sequencer
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  import pipe_ctrl_pkg::*;
  logic              id_stallreq;
  logic              ex_div_req;
  logic              div_done;
  logic              mem_stallreq;
  logic              excp_req;
  logic [31:0]       excp_pc;
  logic [STAGES-1:0] stall;
  logic              div_start;
  logic              div_abort;
  logic              flush;
  logic [31:0]       new_pc;
  logic              timeout;
  logic [CNT_W-1:0]  stall_cycles;
  modport master (
    output id_stallreq, ex_div_req, div_done, mem_stallreq, excp_req, excp_pc,
    input  stall, div_start, div_abort, flush, new_pc, timeout, stall_cycles
  );
  modport slave (
    input  id_stallreq, ex_div_req, div_done, mem_stallreq, excp_req, excp_pc,
    output stall, div_start, div_abort, flush, new_pc, timeout, stall_cycles
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts consecutive pending-stall cycles and pulses expire on the last allowed one
module ctrl_wait_timer #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic pend,
  output logic expire
);
  localparam int W = $clog2(MAX_WAIT);
  logic [W-1:0] wait_q, wait_d;
  // expire on the MAX_WAIT-th pending cycle; restart whenever the stall clears or expires
  always_comb begin
    expire = pend && wait_q == W'(MAX_WAIT - 1);
    wait_d = pend && !expire ? wait_q + 1'b1 : '0;
  end
  // counter register
  always_ff @(posedge clk) wait_q <= rst ? '0 : wait_d;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer merging hazard, divide, memory and exception requests
module pipe_ctrl import pipe_ctrl_pkg::*; #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_ctrl_if.slave  bus
);
  state_e            state_q, state_d;
  logic              flush_q, flush_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAGES-1:0] stall;
  logic              busy, pend, expire, start;
  ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .pend   (pend),
    .expire (expire)
  );
  // single priority chain: exception, flush slot, memory wait, divide, divide launch, load-use
  always_comb begin
    busy  = state_q == S_DIV_BUSY;
    pend  = !bus.excp_req && state_q != S_FLUSH && (bus.mem_stallreq || (busy && !bus.div_done));
    start = state_q == S_RUN && !bus.excp_req && !bus.mem_stallreq && bus.ex_div_req;
    stall = bus.excp_req         ? STALL_MEM
          : state_q == S_FLUSH   ? STALL_NONE
          : bus.mem_stallreq     ? STALL_MEM
          : busy                 ? (bus.div_done ? STALL_NONE : STALL_EX)
          : bus.ex_div_req       ? STALL_EX
          : bus.id_stallreq      ? STALL_ID
          :                        STALL_NONE;
    state_d = bus.excp_req                                  ? S_FLUSH
            : expire                                        ? S_RUN
            : state_q == S_FLUSH                            ? S_RUN
            : busy && !bus.mem_stallreq && bus.div_done     ? S_RUN
            : start                                         ? S_DIV_BUSY
            :                                                 state_q;
    flush_d   = bus.excp_req;
    new_pc_d  = bus.excp_req ? bus.excp_pc : new_pc_q;
    timeout_d = timeout_q | expire;
    cnt_d     = |stall && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    bus.stall     = stall;
    bus.div_start = !rst && start;
    bus.div_abort = !rst && busy && (bus.excp_req || expire);
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      new_pc_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
      new_pc_q  <= new_pc_d;
      cnt_q     <= cnt_d;
    end
  end
  assign bus.flush        = flush_q;
  assign bus.new_pc       = new_pc_q;
  assign bus.timeout      = timeout_q;
  assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_pipe_ctrl;
  localparam int     MAX_WAIT = 8;
  localparam int     CNT_W    = 6;
  localparam longint CMAX     = (64'd1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit          m_busy = 0, m_fl = 0, m_to = 0;
  int          m_wait = 0;
  logic [31:0] m_pc = '0;
  longint      m_cnt = 0;
  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit id, input bit ex, input bit dd, input bit mem,
                      input bit exc, input logic [31:0] pc);
    logic [5:0] e_stall;
    bit e_start, e_abort, stalled, expire, n_busy;
    @(negedge clk);
    rst = r;
    bus.id_stallreq = id;
    bus.ex_div_req = ex;
    bus.div_done = dd;
    bus.mem_stallreq = mem;
    bus.excp_req = exc;
    bus.excp_pc = pc;
    #1;
    e_start = 0;
    e_abort = 0;
    stalled = 0;
    n_busy = m_busy;
    if (exc) begin
      e_stall = 6'b011111;
      e_abort = m_busy;
      n_busy = 0;
    end else if (m_fl) e_stall = 6'b0;
    else if (mem) begin
      e_stall = 6'b011111;
      stalled = 1;
    end else if (m_busy) begin
      e_stall = dd ? 6'b0 : 6'b001111;
      stalled = !dd;
      n_busy = !dd;
    end else if (ex) begin
      e_stall = 6'b001111;
      e_start = 1;
      n_busy = 1;
    end else e_stall = id ? 6'b000111 : 6'b0;
    expire = stalled && m_wait == MAX_WAIT - 1;
    if (expire) begin
      e_abort = m_busy;
      n_busy = 0;
    end
    if (r) begin
      e_start = 0;
      e_abort = 0;
    end
    chk("stall", 64'(bus.stall), 64'(e_stall));
    chk("div_start", 64'(bus.div_start), 64'(e_start));
    chk("div_abort", 64'(bus.div_abort), 64'(e_abort));
    chk("flush", 64'(bus.flush), 64'(m_fl));
    chk("new_pc", 64'(bus.new_pc), 64'(m_pc));
    chk("timeout", 64'(bus.timeout), 64'(m_to));
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_cnt));
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 0; m_fl = 0; m_to = 0; m_wait = 0; m_pc = '0; m_cnt = 0;
    end else begin
      m_wait = stalled && !expire ? m_wait + 1 : 0;
      m_to = m_to | expire;
      if (e_stall != 0 && m_cnt < CMAX) m_cnt++;
      if (exc) m_pc = pc;
      m_fl = exc;
      m_busy = n_busy;
    end
  endtask
  initial begin
    int mem_pct;
    bus.id_stallreq = 0;
    bus.ex_div_req = 0;
    bus.div_done = 0;
    bus.mem_stallreq = 0;
    bus.excp_req = 0;
    bus.excp_pc = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_cnt", 64'(bus.stall_cycles), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("id_cnt", 64'(bus.stall_cycles), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("id_cnt_hold", 64'(bus.stall_cycles), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 32'h0000_0040);
    chk("excp_flush", 64'(bus.flush), 64'd1);
    chk("excp_new_pc", 64'(bus.new_pc), 64'h40);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("excp_flush_drop", 64'(bus.flush), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < MAX_WAIT - 1; i++) step(0, 0, 1, 0, 0, 0, 0);
    chk("wd_not_yet", 64'(bus.timeout), 64'd0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("wd_timeout", 64'(bus.timeout), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    chk("wd_sticky", 64'(bus.timeout), 64'd1);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("rst_div_timeout", 64'(bus.timeout), 64'd0);
    chk("rst_div_cnt", 64'(bus.stall_cycles), 64'd0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    mem_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) mem_pct = ($urandom_range(1) == 1) ? 90 : 15;
      step($urandom_range(299) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
           $urandom_range(11) == 0, $urandom_range(99) < mem_pct, $urandom_range(19) == 0,
           $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
